// File: rtl/ring_scan_driver.sv
// rtl/ring_scan_driver.sv - one-hot ring phase to multiplexed 7-segment digit driver with dead-time blanking
module ring_scan_driver #(
    parameter int WIDTH       = 4,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [WIDTH-1:0]          ring_in,
    input  logic [4*WIDTH-1:0]        data_in,
    input  logic                      err_clr,
    output logic [WIDTH-1:0]          dig_en,
    output logic [6:0]                seg,
    output logic [$clog2(WIDTH)-1:0]  idx,
    output logic                      active,
    output logic                      err_onehot,
    output logic                      err_seq
);

    localparam int IW  = $clog2(WIDTH);
    localparam int DCW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ring_q, ring_d;
    logic [DCW-1:0]   dcnt_q, dcnt_d;
    logic [WIDTH-1:0] dig_en_q, dig_en_d;
    logic [6:0]       seg_q, seg_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             err_onehot_q, err_onehot_d;
    logic             err_seq_q, err_seq_d;

    logic             change;
    logic             in_onehot;
    logic [WIDTH-1:0] succ;
    logic             onehot_set;
    logic             seq_set;
    logic [IW-1:0]    cur_idx;
    logic [3:0]       cur_digit;

    // Segment pattern {g,f,e,d,c,b,a} for a hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign change    = (ring_in != ring_q);
    assign in_onehot = (ring_in != '0) && ((ring_in & (ring_in - 1'b1)) == '0);
    // Upstream ring rotates right: bit 0 wraps to the top.
    assign succ      = {ring_q[0], ring_q[WIDTH-1:1]};

    // Binary index and selected digit of the held phase (ring_q is one-hot whenever it is used).
    always_comb begin
        cur_idx   = '0;
        cur_digit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_q[i]) begin
                cur_idx   = cur_idx | IW'(i);
                cur_digit = cur_digit | data_in[4*i +: 4];
            end
        end
    end

    // Next-state logic: phase tracking, dead-time countdown and error detection.
    always_comb begin
        state_d    = state_q;
        ring_d     = ring_q;
        dcnt_d     = dcnt_q;
        onehot_set = 1'b0;
        seq_set    = 1'b0;
        if (change) begin
            ring_d = ring_in;
            if (in_onehot) begin
                state_d = BLANK;
                dcnt_d  = DCW'(DEAD_CYCLES - 1);
                // Only a running scan has a meaningful predecessor to check against.
                if (((state_q == BLANK) || (state_q == DRIVE)) && (ring_in != succ)) begin
                    seq_set = 1'b1;
                end
            end else begin
                state_d    = FAULT;
                dcnt_d     = '0;
                onehot_set = 1'b1;
            end
        end else begin
            case (state_q)
                BLANK: begin
                    if (dcnt_q == '0) begin
                        state_d = DRIVE;
                    end else begin
                        dcnt_d = dcnt_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs follow the next state so blanking lasts exactly DEAD_CYCLES clocks; set beats clear on flags.
    always_comb begin
        dig_en_d     = '0;
        seg_d        = '0;
        idx_d        = '0;
        err_onehot_d = err_onehot_q;
        err_seq_d    = err_seq_q;
        if (state_d == DRIVE) begin
            dig_en_d = ring_q;
            idx_d    = cur_idx;
            seg_d    = hex7(cur_digit);
        end
        if (err_clr) begin
            err_onehot_d = 1'b0;
            err_seq_d    = 1'b0;
        end
        if (onehot_set) begin
            err_onehot_d = 1'b1;
        end
        if (seq_set) begin
            err_seq_d = 1'b1;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            ring_q       <= '0;
            dcnt_q       <= '0;
            dig_en_q     <= '0;
            seg_q        <= '0;
            idx_q        <= '0;
            err_onehot_q <= 1'b0;
            err_seq_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_q       <= ring_d;
            dcnt_q       <= dcnt_d;
            dig_en_q     <= dig_en_d;
            seg_q        <= seg_d;
            idx_q        <= idx_d;
            err_onehot_q <= err_onehot_d;
            err_seq_q    <= err_seq_d;
        end
    end

    assign dig_en     = dig_en_q;
    assign seg        = seg_q;
    assign idx        = idx_q;
    assign active     = (state_q == DRIVE);
    assign err_onehot = err_onehot_q;
    assign err_seq    = err_seq_q;

endmodule

// File: doc/ring_scan_driver.md
RING_SCAN_DRIVER -- requirements
Module: ring_scan_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the number of display digits and the width of the one-hot phase input (2..16).
REQ-002 SHALL have parameter DEAD_CYCLES, default 2, meaning the number of blanking clocks after every phase change (>=1).
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port ring_in, input, WIDTH bits, meaning the one-hot phase from the upstream ring counter.
REQ-006 SHALL have port data_in, input, 4*WIDTH bits, meaning hex digit values, with digit i at data_in[4i+3:4i].
REQ-007 SHALL have port err_clr, input, 1 bit, meaning a synchronous clear of both sticky error flags.
REQ-008 SHALL have port dig_en, output, WIDTH bits, meaning active-high digit enables, registered, at most one bit high.
REQ-009 SHALL have port seg, output, 7 bits, meaning active-high segments {g,f,e,d,c,b,a}, registered.
REQ-010 SHALL have port idx, output, clog2(WIDTH) bits, meaning the binary index of the driven digit.
REQ-011 SHALL have port active, output, 1 bit, meaning the state is DRIVE.
REQ-012 SHALL have port err_onehot, output, 1 bit, meaning a sticky flag set when a non-one-hot phase is captured.
REQ-013 SHALL have port err_seq, output, 1 bit, meaning a sticky flag set on an illegal phase succession.

Function
REQ-014 SHALL keep the state register ring_q (WIDTH bits), the FSM states IDLE, BLANK, DRIVE and FAULT, and the dead-time counter dcnt.
REQ-015 SHALL, on each edge where ring_in != ring_q ("change"), load ring_q <= ring_in.
REQ-016 SHALL, on a change to a one-hot value, go to BLANK with dcnt = DEAD_CYCLES-1, from any state.
REQ-017 SHALL, on a change to a zero or multi-bit value, go to FAULT and set err_onehot.
REQ-018 SHALL define the legal successor of ring_q as a rotate-right by one: new[i] = old[i+1], new[WIDTH-1] = old[0] (e.g. 0001->1000->0100->0010->0001).
REQ-019 SHALL set err_seq on a change from BLANK or DRIVE to a one-hot value that is not the legal successor, and still proceed to BLANK (resync).
REQ-020 SHALL perform no succession check on changes taken from IDLE or FAULT.
REQ-021 SHALL, in BLANK with no change, decrement dcnt and enter DRIVE at the edge where dcnt == 0, so that dig_en is 0 for exactly DEAD_CYCLES clocks.
REQ-022 SHALL, when a change occurs during BLANK, restart blanking per REQ-016 or REQ-017.
REQ-023 SHALL, in DRIVE, register dig_en <= ring_q, idx <= the bit position of ring_q, and seg <= hex7(data_in digit idx), updating every clock (1-cycle latency from data_in).
REQ-024 SHALL, in IDLE, BLANK and FAULT, register dig_en = 0, seg = 0, idx = 0 and active = 0.
REQ-025 SHALL stay in IDLE, with no error, while ring_in == ring_q; a stable zero is legal only in IDLE.
REQ-026 SHALL stay in FAULT until the next change to a one-hot value.
REQ-027 SHALL use the hex7 table 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71.
REQ-028 SHALL clear both sticky flags on err_clr; a same-cycle error set SHALL win over err_clr.

Reset
REQ-029 SHALL, while rstn is low, immediately force state = IDLE, ring_q = 0, dcnt = 0, and every output (dig_en, seg, idx, active, err_onehot, err_seq) to 0, regardless of clk.
REQ-030 SHALL, on assertion of rstn mid-DRIVE or mid-BLANK, blank the outputs at once; after release, the first one-hot ring_in re-enters via BLANK.

Verification
REQ-031 SHALL cover: reset, then ring_in=0001 with data_in=0x8421 -> dig_en=0 for 2 clocks, then dig_en=0001, idx=0, seg=06, active=1.
REQ-032 SHALL cover: a full legal rotation 0001->1000->0100->0010->0001 -> each step blanks 2 clocks, seg shows 8,4,2,1, and err_seq stays 0.
REQ-033 SHALL cover: ring_in jumps 0001->0100 -> err_seq=1, then dig_en=0100 after blanking; with err_clr pulsed -> err_seq=0.
REQ-034 SHALL cover: ring_in=0110 -> FAULT, dig_en=0, err_onehot=1; then ring_in=0010 -> BLANK then DRIVE, with err_seq unchanged.
REQ-035 SHALL cover: ring_in changes during the 1st blank clock -> blanking restarts, with 2 full dead clocks after the last change.
REQ-036 SHALL cover: rstn pulsed low asynchronously mid-DRIVE -> all outputs are 0 before the next clk edge.
